// File: rtl/vga_pkg.sv
// Shared VGA timing constants, counter widths and sync decoder FSM encoding.
// Default geometry is 800x600 with 1056-clock lines and 628-line frames.
package vga_pkg;

  localparam int XW = 11;
  localparam int YW = 10;

  localparam int HA_END = 799;
  localparam int HS_STA = 840;
  localparam int LINE   = 1056;
  localparam int VA_END = 599;
  localparam int VS_STA = 600;
  localparam int SCREEN = 628;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop input register with rise/fall strobes.
// Strobes compare the first and second stage.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

endmodule

// File: rtl/vga_sync_decoder.sv
// Hs/Vs timing measurement, lock FSM and pixel coordinate recovery.
// Define VGA_SYNC_DECODER_ACTIVE_EN to add the registered ACTIVE port.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int HS_RISE_X   = HS_STA,
  parameter int VS_RISE_Y   = VS_STA,
`ifdef VGA_SYNC_DECODER_ACTIVE_EN
  parameter int HA_END      = vga_pkg::HA_END,
  parameter int VA_END      = vga_pkg::VA_END,
`endif
  parameter int LOCK_FRAMES = 2
) (
  input  logic          PIXEL_CLOCK,
  input  logic          RESET_N,
  input  logic          Hs,
  input  logic          Vs,
  output logic [XW-1:0] LINE_LEN,
  output logic [XW-1:0] HS_WIDTH,
  output logic [YW-1:0] FRAME_LINES,
  output logic [YW-1:0] VS_WIDTH,
  output logic          LOCKED,
  output logic          NO_SIGNAL,
  output logic [XW-1:0] REC_X,
  output logic [YW-1:0] REC_Y
`ifdef VGA_SYNC_DECODER_ACTIVE_EN
  ,
  output logic          ACTIVE
`endif
);

  localparam logic [XW-1:0] X_LOAD = XW'(HS_RISE_X);
  localparam logic [YW-1:0] Y_LOAD = YW'(VS_RISE_Y);
  localparam logic [2:0]    LF     = 3'(LOCK_FRAMES);

  logic hs_rise, hs_fall;
  logic vs_rise, vs_fall;

  sync_edge_detect u_hs (
    .clk   (PIXEL_CLOCK),
    .rst_n (RESET_N),
    .d     (Hs),
    .rise  (hs_rise),
    .fall  (hs_fall)
  );

  sync_edge_detect u_vs (
    .clk   (PIXEL_CLOCK),
    .rst_n (RESET_N),
    .d     (Vs),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  sync_state_t   state;
  logic [2:0]    match;
  logic [XW-1:0] h_cnt, hs_w_cap, first_len;
  logic [XW-1:0] rec_x;
  logic [YW-1:0] v_cnt, vs_cnt, vs_w_cap;
  logic [YW-1:0] prev_frame, rec_y;
  logic          vs_hi, got_first, line_ok;

  logic [XW-1:0] h_meas;
  logic          timeout, frame_ok;
  logic          lock_bad;

  assign h_meas  = h_cnt + 1'b1;
  assign timeout = ~hs_rise & (h_cnt >= 11'd2046);

  assign frame_ok = got_first & line_ok &
                    (v_cnt == prev_frame);

  assign lock_bad =
    (hs_rise & (h_meas != LINE_LEN)) |
    (vs_rise & (v_cnt != FRAME_LINES));

  // vs_hi mirrors the second Vs register stage
  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt      <= '0;
      hs_w_cap   <= '0;
      v_cnt      <= '0;
      vs_hi      <= 1'b0;
      vs_cnt     <= '0;
      vs_w_cap   <= '0;
      got_first  <= 1'b0;
      first_len  <= '0;
      line_ok    <= 1'b0;
      prev_frame <= '0;
      NO_SIGNAL  <= 1'b0;
    end else begin
      if (hs_rise)
        h_cnt <= '0;
      else if (h_cnt != '1)
        h_cnt <= h_meas;

      if (hs_fall)
        hs_w_cap <= h_meas;

      if (vs_rise)
        v_cnt <= {{(YW-1){1'b0}}, hs_rise};
      else if (hs_rise && v_cnt != '1)
        v_cnt <= v_cnt + 1'b1;

      if (vs_rise)
        vs_hi <= 1'b1;
      else if (vs_fall)
        vs_hi <= 1'b0;

      if (vs_rise)
        vs_cnt <= '0;
      else if (hs_rise && vs_hi && vs_cnt != '1)
        vs_cnt <= vs_cnt + 1'b1;

      if (vs_fall)
        vs_w_cap <= vs_cnt + YW'(hs_rise & vs_hi);

      if (vs_rise) begin
        got_first  <= hs_rise;
        first_len  <= h_meas;
        line_ok    <= 1'b1;
        prev_frame <= v_cnt;
      end else if (hs_rise) begin
        if (!got_first) begin
          got_first <= 1'b1;
          first_len <= h_meas;
        end else if (h_meas != first_len) begin
          line_ok <= 1'b0;
        end
      end

      if (hs_rise)
        NO_SIGNAL <= 1'b0;
      else if (timeout)
        NO_SIGNAL <= 1'b1;
    end
  end

  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_HUNT;
      match       <= '0;
      LINE_LEN    <= '0;
      HS_WIDTH    <= '0;
      FRAME_LINES <= '0;
      VS_WIDTH    <= '0;
    end else if (timeout) begin
      state <= ST_HUNT;
      match <= '0;
    end else begin
      unique case (state)
        ST_HUNT: begin
          if (vs_rise) begin
            state <= ST_MEASURE;
            match <= '0;
          end
        end
        ST_MEASURE: begin
          if (vs_rise) begin
            if (frame_ok) begin
              LINE_LEN    <= first_len;
              HS_WIDTH    <= hs_w_cap;
              FRAME_LINES <= v_cnt;
              VS_WIDTH    <= vs_w_cap;
              if (match + 3'd1 == LF) begin
                state <= ST_LOCKED;
                match <= '0;
              end else begin
                match <= match + 3'd1;
              end
            end else begin
              match <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (lock_bad) begin
            state <= ST_HUNT;
          end else if (vs_rise) begin
            LINE_LEN    <= first_len;
            HS_WIDTH    <= hs_w_cap;
            FRAME_LINES <= v_cnt;
            VS_WIDTH    <= vs_w_cap;
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rec_x <= '0;
      rec_y <= '0;
    end else begin
      if (hs_rise)
        rec_x <= X_LOAD;
      else if (rec_x == LINE_LEN - 1'b1)
        rec_x <= '0;
      else
        rec_x <= rec_x + 1'b1;

      if (vs_rise)
        rec_y <= Y_LOAD;
      else if (hs_rise) begin
        if (rec_y == FRAME_LINES - 1'b1)
          rec_y <= '0;
        else
          rec_y <= rec_y + 1'b1;
      end
    end
  end

  assign LOCKED = (state == ST_LOCKED);
  assign REC_X  = LOCKED ? rec_x : '0;
  assign REC_Y  = LOCKED ? rec_y : '0;

`ifdef VGA_SYNC_DECODER_ACTIVE_EN
  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      ACTIVE <= 1'b0;
    else
      ACTIVE <= LOCKED &&
                (REC_X <= XW'(HA_END)) &&
                (REC_Y <= YW'(VA_END));
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled 100x20 raster.
// Define VGA_SYNC_DECODER_ACTIVE_EN to also check ACTIVE.
module tb_vga_sync_decoder;

  localparam int LN   = 100;
  localparam int HW   = 12;
  localparam int FL   = 20;
  localparam int VW   = 3;
  localparam int VS_P = 50;
  localparam int HX   = 84;
  localparam int VY   = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs, vs;
  logic [10:0] line_len, hs_width, rec_x;
  logic [9:0]  frame_lines, vs_width, rec_y;
  logic        locked, no_signal;
`ifdef VGA_SYNC_DECODER_ACTIVE_EN
  logic        active;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk      = 0;
  bit chk_bad  = 0;
  bit chk_ns   = 0;
  int bad_ln   = -1;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .HS_RISE_X   (HX),
    .VS_RISE_Y   (VY),
`ifdef VGA_SYNC_DECODER_ACTIVE_EN
    .HA_END      (79),
    .VA_END      (14),
`endif
    .LOCK_FRAMES (2)
  ) dut (
    .PIXEL_CLOCK (clk),
    .RESET_N     (rst_n),
    .Hs          (hs),
    .Vs          (vs),
    .LINE_LEN    (line_len),
    .HS_WIDTH    (hs_width),
    .FRAME_LINES (frame_lines),
    .VS_WIDTH    (vs_width),
    .LOCKED      (locked),
    .NO_SIGNAL   (no_signal),
    .REC_X       (rec_x),
    .REC_Y       (rec_y)
`ifdef VGA_SYNC_DECODER_ACTIVE_EN
    ,
    .ACTIVE      (active)
`endif
  );

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int j, input int len);
    for (int p = 0; p < len; p++) begin
      hs = (p < HW);
      if (p == VS_P && j == 0)  vs = 1'b1;
      if (p == VS_P && j == VW) vs = 1'b0;
      tick();
      if (chk) begin
        if (j == 0 && p == VS_P)
          check("lock_pre", locked, 0);
        if (j == 0 && p == VS_P + 1) begin
          check("lock_rise", locked, 1);
          check("y_load", rec_y, VY);
        end
        if (j == 1 && p == 1)  check("x_load", rec_x, HX);
        if (j == 1 && p == 16) check("x_last", rec_x, LN - 1);
        if (j == 1 && p == 17) check("x_wrap", rec_x, 0);
        if (j == 4 && p == 60) check("y_last", rec_y, FL - 1);
        if (j == 5 && p == 60) check("y_wrap", rec_y, 0);
`ifdef VGA_SYNC_DECODER_ACTIVE_EN
        if (j == 19 && p == 97) check("act_on", active, 1);
        if (j == 19 && p == 98) check("act_off", active, 0);
`endif
      end
      if (chk_bad && j == bad_ln + 1) begin
        if (p == 0) check("bad_pre", locked, 1);
        if (p == 1) check("bad_drop", locked, 0);
      end
      if (chk_ns && j == 0) begin
        if (p == 0) check("ns_pre", no_signal, 1);
        if (p == 1) check("ns_clr", no_signal, 0);
      end
    end
  endtask

  task automatic run_frame(input int bad);
    for (int j = 0; j < FL; j++)
      run_line(j, (j == bad) ? LN + 1 : LN);
  endtask

  task automatic check_meas(input string tag);
    check({tag, "_line"},  line_len,    LN);
    check({tag, "_hsw"},   hs_width,    HW);
    check({tag, "_frame"}, frame_lines, FL);
    check({tag, "_vsw"},   vs_width,    VW);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_line"},  line_len,    0);
    check({tag, "_hsw"},   hs_width,    0);
    check({tag, "_frame"}, frame_lines, 0);
    check({tag, "_vsw"},   vs_width,    0);
    check({tag, "_lock"},  locked,      0);
    check({tag, "_ns"},    no_signal,   0);
    check({tag, "_x"},     rec_x,       0);
    check({tag, "_y"},     rec_y,       0);
`ifdef VGA_SYNC_DECODER_ACTIVE_EN
    check({tag, "_act"},   active,      0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    hs    = 1'b0;
    vs    = 1'b0;
    repeat (3) tick();
    check_zero("rst");
    rst_n = 1'b1;
    tick();

    run_frame(-1);
    run_frame(-1);
    run_frame(-1);
    check("f3_lock", locked, 0);
    check("f3_line", line_len, LN);

    chk = 1;
    run_frame(-1);
    chk = 0;
    check_meas("lk");
    check("lk_ns", no_signal, 0);

    bad_ln  = 10;
    chk_bad = 1;
    run_frame(bad_ln);
    chk_bad = 0;
    check("hold_line", line_len, LN);
    run_frame(-1);
    run_frame(-1);
    check("relock_pre", locked, 0);
    chk = 1;
    run_frame(-1);
    chk = 0;

    hs = 1'b0;
    repeat (2100) tick();
    check("to_ns", no_signal, 1);
    check("to_lock", locked, 0);
    check("to_hold", line_len, LN);
    chk_ns = 1;
    run_frame(-1);
    chk_ns = 0;
    run_frame(-1);
    chk = 1;
    run_frame(-1);
    chk = 0;

    run_line(0, LN);
    run_line(1, LN);
    for (int p = 0; p < 40; p++) begin
      hs = (p < HW);
      tick();
    end
    check("pre_rst_lock", locked, 1);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    tick();
    tick();
    rst_n = 1'b1;
    hs    = 1'b0;
    vs    = 1'b0;
    tick();

    run_frame(-1);
    run_frame(-1);
    run_frame(-1);
    chk = 1;
    run_frame(-1);
    chk = 0;
    check_meas("re");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
